// File: rtl/prim_ram_2p_pkg.sv
// Shared types and limits for the two-port pipelined RAM.
package prim_ram_2p_pkg;

    // Technology configuration word; carried for macro compatibility only.
    typedef struct packed {
        logic       cfg_en;
        logic [3:0] cfg;
    } ram_2p_cfg_t;

    localparam int MaxReadLatency = 4;

endpackage

// File: rtl/prim_ram_2p_rd_pipe.sv
// Per-port read return pipeline: valid/data/err shift through ReadLatency
// register stages. The last stage only loads on a valid read so the
// output data holds between reads.
module prim_ram_2p_rd_pipe
    import prim_ram_2p_pkg::*;
#(
    parameter int Width       = 32,
    parameter int ReadLatency = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             vld_i,
    input  logic [Width-1:0] data_i,
    input  logic             err_i,
    output logic             rvalid_o,
    output logic [Width-1:0] rdata_o,
    output logic             err_o
);

    localparam int Stages = ReadLatency - 1;

    logic [Stages:0]            vld_pipe, vld_nxt;
    logic [Stages:0][Width-1:0] data_pipe, data_nxt;
    logic [Stages:0]            err_pipe, err_nxt;

    // Stage inputs: stage 0 takes the new read, later stages the previous one.
    always_comb begin
        vld_nxt     = '0;
        data_nxt    = '0;
        err_nxt     = '0;
        vld_nxt[0]  = vld_i;
        data_nxt[0] = data_i;
        err_nxt[0]  = err_i;
        for (int i = 1; i <= Stages; i++) begin
            vld_nxt[i]  = vld_pipe[i-1];
            data_nxt[i] = data_pipe[i-1];
            err_nxt[i]  = err_pipe[i-1];
        end
    end

    // Shift valids every cycle; data/err only move with a valid so stages hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
            err_pipe  <= '0;
        end else begin
            vld_pipe <= vld_nxt;
            for (int i = 0; i <= Stages; i++) begin
                if (vld_nxt[i]) begin
                    data_pipe[i] <= data_nxt[i];
                    err_pipe[i]  <= err_nxt[i];
                end
            end
        end
    end

    assign rvalid_o = vld_pipe[Stages];
    assign rdata_o  = data_pipe[Stages];
    assign err_o    = err_pipe[Stages];

    // Latency must fit the supported pipeline depth.
    a_latency_range : assert property (@(posedge clk_i)
        (ReadLatency >= 1) && (ReadLatency <= MaxReadLatency))
        else $error("ReadLatency out of range");

endmodule

// File: rtl/prim_ram_2p_pipe.sv
// Two-port RAM on one clock with masked writes, configurable read latency,
// out-of-range error reporting and same-address collision signalling.
module prim_ram_2p_pipe
    import prim_ram_2p_pkg::*;
#(
    parameter int    Width           = 32,
    parameter int    Depth           = 128,
    parameter int    DataBitsPerMask = 1,
    parameter int    ReadLatency     = 1,
    parameter int    WriteFirst      = 0,
    parameter string MemInitFile     = "",
    localparam int   Aw              = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             a_req_i,
    input  logic             a_write_i,
    input  logic [Aw-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [Width-1:0] a_wmask_i,
    output logic             a_rvalid_o,
    output logic [Width-1:0] a_rdata_o,
    output logic             a_err_o,
    input  logic             b_req_i,
    input  logic             b_write_i,
    input  logic [Aw-1:0]    b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    input  logic [Width-1:0] b_wmask_i,
    output logic             b_rvalid_o,
    output logic [Width-1:0] b_rdata_o,
    output logic             b_err_o,
    output logic             collision_o,
    input  ram_2p_cfg_t      cfg_i
);

    localparam int NumGroups = Width / DataBitsPerMask;

    logic [Width-1:0] mem [Depth];

    logic unused_cfg;
    assign unused_cfg = ^cfg_i;

    // Masks are uniform per group, so a bitwise merge equals a group merge.
    function automatic logic [Width-1:0] merge(input logic [Width-1:0] base,
                                               input logic [Width-1:0] data,
                                               input logic [Width-1:0] mask);
        return (base & ~mask) | (data & mask);
    endfunction

    function automatic logic mask_ok(input logic [Width-1:0] m);
        for (int g = 0; g < NumGroups; g++) begin
            if (m[g*DataBitsPerMask +: DataBitsPerMask] != '0 &&
                m[g*DataBitsPerMask +: DataBitsPerMask] != '1) return 1'b0;
        end
        return 1'b1;
    endfunction

    logic a_in, b_in, same, a_we, b_we, a_re, b_re, coll_d, collision_q;
    logic [Width-1:0] a_old, b_old, a_wr_word, b_wr_word, a_rd_word, b_rd_word;

    assign a_in = 32'(a_addr_i) < 32'(Depth);
    assign b_in = 32'(b_addr_i) < 32'(Depth);
    assign same = a_addr_i == b_addr_i;
    assign a_we = a_req_i & a_write_i & a_in;
    assign b_we = b_req_i & b_write_i & b_in;
    assign a_re = a_req_i & ~a_write_i;
    assign b_re = b_req_i & ~b_write_i;

    assign a_old = a_in ? mem[a_addr_i] : '0;
    assign b_old = b_in ? mem[b_addr_i] : '0;

    // On a shared address both ports write the same word: B's groups first, A's on top.
    assign b_wr_word = (a_we && same) ? merge(merge(b_old, b_wdata_i, b_wmask_i), a_wdata_i, a_wmask_i)
                                      : merge(b_old, b_wdata_i, b_wmask_i);
    assign a_wr_word = (b_we && same) ? b_wr_word : merge(a_old, a_wdata_i, a_wmask_i);

    // Read word, optionally bypassing the other port's same-cycle write.
    assign a_rd_word = !a_in ? '0 :
                       (WriteFirst != 0 && b_we && same) ? merge(a_old, b_wdata_i, b_wmask_i) : a_old;
    assign b_rd_word = !b_in ? '0 :
                       (WriteFirst != 0 && a_we && same) ? merge(b_old, a_wdata_i, a_wmask_i) : b_old;

    // Array update; not reset so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (b_we) mem[b_addr_i] <= b_wr_word;
        if (a_we) mem[a_addr_i] <= a_wr_word;
    end

    // Same in-range address with at least one writer is a collision.
    assign coll_d = a_req_i & b_req_i & same & a_in & (a_write_i | b_write_i);

    // Collision reported one cycle after the conflicting requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) collision_q <= 1'b0;
        else         collision_q <= coll_d;
    end

    assign collision_o = collision_q;

    prim_ram_2p_rd_pipe #(.Width(Width), .ReadLatency(ReadLatency)) u_rd_pipe_a (
        .clk_i, .rst_ni, .vld_i(a_re), .data_i(a_rd_word), .err_i(~a_in),
        .rvalid_o(a_rvalid_o), .rdata_o(a_rdata_o), .err_o(a_err_o));

    prim_ram_2p_rd_pipe #(.Width(Width), .ReadLatency(ReadLatency)) u_rd_pipe_b (
        .clk_i, .rst_ni, .vld_i(b_re), .data_i(b_rd_word), .err_i(~b_in),
        .rvalid_o(b_rvalid_o), .rdata_o(b_rdata_o), .err_o(b_err_o));

    a_width_div : assert property (@(posedge clk_i) (Width % DataBitsPerMask) == 0)
        else $error("Width not divisible by DataBitsPerMask");
    a_mask_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (a_req_i && a_write_i) |-> mask_ok(a_wmask_i)) else $error("port A mask not group-uniform");
    a_mask_b : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (b_req_i && b_write_i) |-> mask_ok(b_wmask_i)) else $error("port B mask not group-uniform");

endmodule

// File: tb/tb_prim_ram_2p_pipe.sv
// Scoreboard bench: two RAM configurations share one stimulus stream.
// dut0: ReadLatency 3, read-first, bit masks. dut1: ReadLatency 1, write-first, byte masks.
module tb_prim_ram_2p_pipe;
    import prim_ram_2p_pkg::*;

    localparam int W  = 32;
    localparam int D  = 100;
    localparam int AW = $clog2(D);

    typedef struct packed { logic [31:0] d; logic e; } exp_t;

    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    logic a_req, a_write, b_req, b_write;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0] a_wdata, a_wmask, b_wdata, b_wmask;
    ram_2p_cfg_t cfg;

    logic a_rv0, a_er0, b_rv0, b_er0, coll0, a_rv1, a_er1, b_rv1, b_er1, coll1;
    logic [W-1:0] a_rd0, b_rd0, a_rd1, b_rd1;

    prim_ram_2p_pipe #(.Width(W), .Depth(D), .DataBitsPerMask(1), .ReadLatency(3), .WriteFirst(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(a_req), .a_write_i(a_write), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_wmask_i(a_wmask),
        .a_rvalid_o(a_rv0), .a_rdata_o(a_rd0), .a_err_o(a_er0),
        .b_req_i(b_req), .b_write_i(b_write), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_wmask_i(b_wmask),
        .b_rvalid_o(b_rv0), .b_rdata_o(b_rd0), .b_err_o(b_er0),
        .collision_o(coll0), .cfg_i(cfg));

    prim_ram_2p_pipe #(.Width(W), .Depth(D), .DataBitsPerMask(8), .ReadLatency(1), .WriteFirst(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(a_req), .a_write_i(a_write), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_wmask_i(a_wmask),
        .a_rvalid_o(a_rv1), .a_rdata_o(a_rd1), .a_err_o(a_er1),
        .b_req_i(b_req), .b_write_i(b_write), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_wmask_i(b_wmask),
        .b_rvalid_o(b_rv1), .b_rdata_o(b_rd1), .b_err_o(b_er1),
        .collision_o(coll1), .cfg_i(cfg));

    exp_t qa0[$], qb0[$], qa1[$], qb1[$];
    int   qc0[$], qc1[$];
    int   total = 0, bad = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per rvalid; collision compared when seen or due.
    always @(negedge clk) begin : mon
        exp_t e;
        logic due;
        if (a_rv0) begin
            if (qa0.size() == 0) chk("a0_spurious_rvalid", 1, 0);
            else begin e = qa0.pop_front(); chk("a0_rdata", a_rd0, e.d); chk("a0_err", 32'(a_er0), 32'(e.e)); end
        end
        if (b_rv0) begin
            if (qb0.size() == 0) chk("b0_spurious_rvalid", 1, 0);
            else begin e = qb0.pop_front(); chk("b0_rdata", b_rd0, e.d); chk("b0_err", 32'(b_er0), 32'(e.e)); end
        end
        if (a_rv1) begin
            if (qa1.size() == 0) chk("a1_spurious_rvalid", 1, 0);
            else begin e = qa1.pop_front(); chk("a1_rdata", a_rd1, e.d); chk("a1_err", 32'(a_er1), 32'(e.e)); end
        end
        if (b_rv1) begin
            if (qb1.size() == 0) chk("b1_spurious_rvalid", 1, 0);
            else begin e = qb1.pop_front(); chk("b1_rdata", b_rd1, e.d); chk("b1_err", 32'(b_er1), 32'(e.e)); end
        end
        due = (qc0.size() > 0) && (qc0[0] == cyc);
        if (coll0 || due) begin
            chk("collision0", 32'(coll0), 32'(due));
            if (due) void'(qc0.pop_front());
        end
        due = (qc1.size() > 0) && (qc1[0] == cyc);
        if (coll1 || due) begin
            chk("collision1", 32'(coll1), 32'(due));
            if (due) void'(qc1.pop_front());
        end
    end

    task automatic idle();
        a_req = 0; a_write = 0; a_addr = '0; a_wdata = '0; a_wmask = '0;
        b_req = 0; b_write = 0; b_addr = '0; b_wdata = '0; b_wmask = '0;
    endtask

    task automatic aop(input logic wr, input logic [AW-1:0] ad, input logic [31:0] d, input logic [31:0] m);
        a_req = 1; a_write = wr; a_addr = ad; a_wdata = d; a_wmask = m;
    endtask

    task automatic bop(input logic wr, input logic [AW-1:0] ad, input logic [31:0] d, input logic [31:0] m);
        b_req = 1; b_write = wr; b_addr = ad; b_wdata = d; b_wmask = m;
    endtask

    task automatic step();
        @(posedge clk); #1; idle();
    endtask

    task automatic push_a(input logic [31:0] d, input logic e);
        qa0.push_back({d, e}); qa1.push_back({d, e});
    endtask

    task automatic push_b(input logic [31:0] d, input logic e);
        qb0.push_back({d, e}); qb1.push_back({d, e});
    endtask

    task automatic push_coll();
        qc0.push_back(cyc + 1); qc1.push_back(cyc + 1);
    endtask

    initial begin
        cfg = '0;
        idle();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a0_rvalid", 32'(a_rv0), 0); chk("rst_a0_rdata", a_rd0, 0);
        chk("rst_b1_rvalid", 32'(b_rv1), 0); chk("rst_b1_rdata", b_rd1, 0);
        chk("rst_err", {28'd0, a_er0, b_er0, a_er1, b_er1}, 0);
        chk("rst_coll", {30'd0, coll0, coll1}, 0);
        rst_n = 1'b1;
        step();

        // basic write then read
        aop(1, 5, 32'hDEADBEEF, 32'hFFFFFFFF); step();
        aop(0, 5, 0, 0); push_a(32'hDEADBEEF, 0); step();
        // dual write same address, A wins low half
        aop(1, 7, 32'h11111111, 32'h0000FFFF); bop(1, 7, 32'h22222222, 32'hFFFFFFFF); push_coll(); step();
        aop(0, 7, 0, 0); push_a(32'h22221111, 0); bop(1, 9, 32'h0000000A, 32'hFFFFFFFF); step();
        // write on A, read on B, same address
        aop(1, 9, 32'h0000000B, 32'hFFFFFFFF); bop(0, 9, 0, 0);
        qb0.push_back({32'h0000000A, 1'b0}); qb1.push_back({32'h0000000B, 1'b0}); push_coll(); step();
        // out-of-range read; B sees new value
        aop(0, 120, 0, 0); push_a(0, 1); bop(0, 9, 0, 0); push_b(32'h0000000B, 0); step();
        aop(1, 120, 32'hFFFFFFFF, 32'hFFFFFFFF); step();
        aop(0, 120, 0, 0); push_a(0, 1); bop(0, 5, 0, 0); push_b(32'hDEADBEEF, 0); step();
        // two reads to one address: no collision
        aop(1, 3, 32'h33CC55AA, 32'hFFFFFFFF); step();
        aop(0, 3, 0, 0); bop(0, 3, 0, 0); push_a(32'h33CC55AA, 0); push_b(32'h33CC55AA, 0); step();
        // byte-granular partial write
        aop(1, 5, 32'h12345678, 32'hFF00FF00); step();
        aop(0, 5, 0, 0); push_a(32'h12AD56EF, 0); step();
        // back-to-back reads return in order
        aop(0, 7, 0, 0); push_a(32'h22221111, 0); step();
        aop(0, 9, 0, 0); push_a(32'h0000000B, 0); step();
        aop(0, 3, 0, 0); push_a(32'h33CC55AA, 0); step();
        repeat (5) step();

        // rdata holds last value while idle
        chk("hold_a0_rdata", a_rd0, 32'h33CC55AA); chk("hold_b0_rdata", b_rd0, 32'h33CC55AA);
        chk("hold_a1_rdata", a_rd1, 32'h33CC55AA); chk("hold_b1_rdata", b_rd1, 32'h33CC55AA);

        // reads in flight at reset are dropped (dut1 returns the first before reset)
        bop(0, 3, 0, 0); qb1.push_back({32'h33CC55AA, 1'b0}); step();
        bop(0, 3, 0, 0); step();
        rst_n = 1'b0;
        bop(0, 3, 0, 0); step();
        bop(0, 3, 0, 0); step();
        step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("post_rst_b0", {b_rd0[30:0], b_rv0}, 0); chk("post_rst_b0_err", 32'(b_er0), 0);
        chk("post_rst_b1", {b_rd1[30:0], b_rv1}, 0); chk("post_rst_a0_rdata", a_rd0, 0);

        chk("drain_qa0", qa0.size(), 0); chk("drain_qb0", qb0.size(), 0);
        chk("drain_qa1", qa1.size(), 0); chk("drain_qb1", qb1.size(), 0);
        chk("drain_qc", qc0.size() + qc1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
